bram_stream_ctrl: RTL
=====================

BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, BRAM address width.
REQ-003 SHALL have parameter RAM_DEPTH, default (1 << ADDR_WIDTH), BRAM word count.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-005 SHALL have port clka, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rsta, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_start, input, 1, begin fill transfer (pulse).
REQ-008 SHALL have port rd_start, input, 1, begin drain transfer (pulse).
REQ-009 SHALL have port xfer_len, input, ADDR_WIDTH+1, word count latched at start.
REQ-010 SHALL have ports s_valid (input, 1), s_data (input, DATA_WIDTH) and s_ready (output, 1), forming the fill stream.
REQ-011 SHALL have ports m_valid (output, 1), m_data (output, DATA_WIDTH) and m_ready (input, 1), forming the drain stream.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at transfer end.
REQ-014 SHALL have ports bram_addra (output, ADDR_WIDTH), bram_dina (output, DATA_WIDTH), bram_ena (output, 1), bram_wea (output, 1) and bram_douta (input, DATA_WIDTH), connecting to the single-port BRAM; read latency 1 cycle.

Function
REQ-015 SHALL implement the states IDLE, WRITE, READ and DONE.
REQ-016 SHALL, in IDLE, move to WRITE on wr_start, or to READ on rd_start; if both are high, wr_start wins.
REQ-017 SHALL, on start, latch len = xfer_len; xfer_len of 0 or greater than RAM_DEPTH SHALL be treated as RAM_DEPTH; pointer SHALL clear to 0.
REQ-018 SHALL ignore wr_start and rd_start outside IDLE.
REQ-019 SHALL, in WRITE, drive s_ready=1; on s_valid&&s_ready in the same cycle, combinationally drive bram_ena=1, bram_wea=1, bram_addra=wr_ptr, bram_dina=s_data, then increment wr_ptr.
REQ-020 SHALL, when the accepted beat is number len, drop s_ready and go to DONE next cycle.
REQ-021 SHALL, in READ, issue a read (bram_ena=1, bram_wea=0, bram_addra=rd_ptr) when rd_ptr<len and (occupancy + inflight - pop) < 2.
REQ-022 SHALL define pop as m_valid&&m_ready.
REQ-023 SHALL capture bram_douta into a 2-entry output buffer one cycle after each issued read.
REQ-024 SHALL present the buffer head as m_data, with m_valid = occupancy>0.
REQ-025 SHALL, with m_ready held high, sustain one beat per cycle; the first m_valid rises 2 cycles after rd_start is sampled.
REQ-026 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-027 SHALL never overflow the buffer and never issue a read past len.
REQ-028 SHALL, after the beat-len pop, go to DONE.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE; busy=0 in that IDLE cycle.
REQ-030 SHALL drive bram_ena=0 and bram_wea=0 in every cycle with no access.
REQ-031 SHALL hold bram_addra and bram_dina at their last values when idle.
REQ-032 SHALL keep pointers ADDR_WIDTH+1 bits wide, so there is no wrap within a transfer.

Reset
REQ-033 SHALL, on rsta=1 (immediately, no clock), set state=IDLE and set s_ready, m_valid, busy, done, bram_ena and bram_wea to 0.
REQ-034 SHALL, on reset, set m_data, bram_addra and bram_dina to 0, and clear pointers, inflight and buffer occupancy.
REQ-035 SHALL, on reset mid-transfer, abort the transfer with no done pulse; BRAM contents are not cleared.
REQ-036 SHALL take its first state change on the first clka edge after rsta deasserts.

Verification
REQ-037 SHALL cover fill: wr_start, xfer_len=4, s_data 0xA0..0xA3 back-to-back -> wea pulses at addr 0..3 on 4 consecutive cycles, then done 1 cycle later.
REQ-038 SHALL cover drain: after fill, rd_start with xfer_len=4 and m_ready=1 -> m_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, first 2 cycles after rd_start, then done.
REQ-039 SHALL cover backpressure: drain len=4 with m_ready toggling 1,0,0,1,... -> no lost or duplicated words, m_data held during stalls, at most 2 reads outstanding plus buffered.
REQ-040 SHALL cover the length boundary: xfer_len=0 with default parameters -> 16 words transferred, addr 0..15, done once.
REQ-041 SHALL cover start collision: wr_start and rd_start in the same cycle -> WRITE entered, s_ready=1, no read issued; rd_start during busy is ignored.
REQ-042 SHALL cover reset mid-transfer: rsta asserted after 2 of 4 fill beats -> outputs immediately at reset values, no done; a later rd_start with len=2 returns the 2 written words.

Source files
------------

// File: rtl/bram_stream_ctrl.sv
// Moves a block of words between a valid/ready stream and a single-port BRAM (fill or drain).
// Fill writes on the accept cycle; drain gives first beat 2 cycles after start, then 1/cycle; stalls held in a 2-entry buffer.
module bram_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = (1 << ADDR_WIDTH)
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  wr_start,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH:0]   xfer_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic                  bram_ena,
    output logic                  bram_wea,
    input  logic [DATA_WIDTH-1:0] bram_douta
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH = LW'(RAM_DEPTH);
    localparam logic [LW-1:0] ONE   = LW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         out_cnt_q, out_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  pop;
    logic [1:0]            occ_after_pop;
    logic [1:0]            occ_net;

    assign s_ready = (state_q == ST_WRITE);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;

    assign pop           = m_valid && m_ready;
    assign wr_fire       = (state_q == ST_WRITE) && s_valid;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign occ_net       = occ_after_pop + {1'b0, inflight_q};
    // A read issued now lands next cycle, so it needs a free slot after this cycle's push and pop.
    assign rd_fire       = (state_q == ST_READ) && (rd_ptr_q < len_q) && (occ_net < 2'd2);

    assign bram_ena   = wr_fire || rd_fire;
    assign bram_wea   = wr_fire;
    assign bram_addra = wr_fire ? wr_ptr_q[ADDR_WIDTH-1:0] :
                        rd_fire ? rd_ptr_q[ADDR_WIDTH-1:0] : addr_q;
    assign bram_dina  = wr_fire ? s_data : din_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_cnt_d  = out_cnt_q;
        inflight_d = rd_fire;
        occ_d      = occ_net;
        buf0_d     = pop ? buf1_q : buf0_q;
        buf1_d     = buf1_q;
        addr_d     = bram_addra;
        din_d      = bram_dina;

        if (inflight_q) begin
            if (occ_after_pop == 2'd0) buf0_d = bram_douta;
            else                       buf1_d = bram_douta;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_start || rd_start) begin
                    len_d     = (xfer_len == '0 || xfer_len > DEPTH) ? DEPTH : xfer_len;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    out_cnt_d = '0;
                    state_d   = wr_start ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (wr_ptr_q + ONE == len_q) state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_fire) rd_ptr_d = rd_ptr_q + ONE;
                if (pop) begin
                    out_cnt_d = out_cnt_q + ONE;
                    if (out_cnt_q + ONE == len_q) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end
endmodule
